i2c_target_mc: RTL
==================

I2C_TARGET_MC -- requirements
Module: i2c_target_mc

Interface
REQ-001 Parameter NUM_CH, default 2, sets the number of target channels, each answering one consecutive 7-bit address (range 1..8).
REQ-002 Parameter BASE_ADDR, default 7'h12, sets the 7-bit address of channel 0; channel k answers at BASE_ADDR+k.
REQ-003 Parameter FIFO_DEPTH, default 8, sets the bytes held by each per-channel TX FIFO and each RX FIFO (power of 2, 2..64).
REQ-004 Localparam CHW = max(1, clog2(NUM_CH)).
REQ-005 Port clk, input, 1 bit: system clock; the block samples all inputs on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port scl_i, input, 1 bit: I2C clock line, asynchronous to clk.
REQ-008 Port sda_i, input, 1 bit: I2C data line, asynchronous to clk.
REQ-009 Port sda_oe, output, 1 bit: 1 pulls SDA low, 0 releases SDA.
REQ-010 Port scl_oe, output, 1 bit: 1 pulls SCL low (clock stretch), 0 releases SCL.
REQ-011 Port tx_wr, input, 1 bit: pushes tx_data into TX FIFO tx_ch.
REQ-012 Port tx_ch, input, CHW bits: selects the TX channel.
REQ-013 Port tx_data, input, 8 bits: TX byte.
REQ-014 Port tx_full, output, NUM_CH bits: per-channel TX FIFO full flags.
REQ-015 Port rx_rd, input, 1 bit: pops RX FIFO rx_ch.
REQ-016 Port rx_ch, input, CHW bits: selects the RX channel.
REQ-017 Port rx_data, output, 8 bits: head of RX FIFO rx_ch, combinational (show-ahead).
REQ-018 Port rx_empty, output, NUM_CH bits: per-channel RX FIFO empty flags.
REQ-019 Port busy, output, 1 bit: high from an addressed START until STOP, NACK, or a non-matching address.
REQ-020 Port act_ch, output, CHW bits: channel of the current or last matched transfer.
REQ-021 Port done, output, 1 bit: one-cycle pulse on each STOP that ends an addressed transfer.

Function
REQ-022 scl_i and sda_i shall pass through 2-flop synchronizers; edges are detected on the synchronized values, giving 3-cycle input latency.
REQ-023 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both are honoured in every state, and a START in mid-transfer is a repeated START.
REQ-024 FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-025 ADDR: 8 bits are sampled MSB first on SCL rising edges; bits[7:1] form the address and bit 0 is R/W.
REQ-026 Address match (BASE_ADDR <= addr < BASE_ADDR+NUM_CH): sda_oe goes high on the next SCL falling edge, is held for one SCL period, and act_ch = addr-BASE_ADDR; no match: no ACK, go to IGNORE until START.
REQ-027 Write (R/W=0): each received byte is ACKed and pushed to the RX FIFO at the 8th SCL rise if that FIFO is not full; if full, the byte is NACKed, dropped, and the FSM goes to IGNORE.
REQ-028 Read (R/W=1): the head of the TX FIFO is popped at the ACK_ADDR/RD_ACK exit, bits are driven on SCL falling edges, and sda_oe = ~bit.
REQ-029 RD_ACK: SDA is sampled at SCL rise; ACK (0) starts the next byte, NACK (1) goes to IGNORE.
REQ-030 A TX FIFO that is empty at a pop point sends 0xFF (behaviour with stretching is in REQ-038).
REQ-031 A simultaneous tx_wr and internal pop on the same channel shall both take effect; occupancy is unchanged.
REQ-032 A simultaneous rx_rd and internal push on the same channel shall both take effect.
REQ-033 tx_wr on a full FIFO and rx_rd on an empty FIFO shall be ignored, with no pointer change.
REQ-034 FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full is MSB differing with the rest equal, and empty is all bits equal.

Reset
REQ-035 While rst=0, outputs shall be: sda_oe=0, scl_oe=0, busy=0, done=0, act_ch=0, tx_full=0, rx_empty=all 1s.
REQ-036 rst=0 shall clear the FSM to IDLE, reset all FIFO pointers to 0, and clear the synchronizers to 1; asserted mid-byte, it releases the lines immediately and asynchronously.

Configuration
REQ-037 Macro I2C_TGT_CLK_STRETCH_EN shall control read-underflow handling.
REQ-038 With I2C_TGT_CLK_STRETCH_EN defined: on a read pop with an empty TX FIFO, scl_oe=1 is held from the SCL falling edge until that FIFO is non-empty, then the byte is loaded and scl_oe=0; a STOP or START received during stretch aborts it.
REQ-039 Without I2C_TGT_CLK_STRETCH_EN: scl_oe is tied to 0 and REQ-030 applies.

Verification
REQ-040 With NUM_CH=2 and FIFO_DEPTH=8: START, 0x24 (0x12 write), bytes 0..7, STOP -> all 9 bytes ACKed; ch0 RX pops return 0..7; done pulses once; act_ch=0.
REQ-041 tx_wr ch1 with 8..15; START, 0x27 (0x13 read), read 8 bytes, ACKing 7 and NACKing the last, STOP -> master receives 8..15; tx_full[1]=0 and ch1 TX is empty.
REQ-042 START, 0x40 (0x20 write), byte 0x55 -> address NACKed; sda_oe stays 0; busy stays 0; no FIFO change.
REQ-043 FIFO_DEPTH=4, write 5 bytes 0xA0..0xA4 to 0x12 -> 0xA4 is NACKed; RX ch0 holds 0xA0..0xA3; a later START is accepted normally.
REQ-044 Write 0x33 to 0x12, repeated START, read 0x12 with ch0 TX empty -> without the macro the master reads 0xFF; with the macro SCL is held low until tx_wr 0x5A, then 0x5A is read.
REQ-045 rst pulsed low during bit 4 of a write byte -> sda_oe=0 and busy=0 without waiting for a clk edge; rx_empty=all 1s; the next START+address is ACKed.

Source files
------------

// File: rtl/i2c_target_mc.sv
// Multi-channel I2C target: NUM_CH consecutive addresses, per-channel TX/RX byte FIFOs.
// Optional read-underflow clock stretching is enabled with I2C_TGT_CLK_STRETCH_EN.
module i2c_target_mc #(
    parameter int          NUM_CH     = 2,
    parameter logic [6:0]  BASE_ADDR  = 7'h12,
    parameter int          FIFO_DEPTH = 8,
    localparam int         CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              scl_oe,
    input  logic              tx_wr,
    input  logic [CHW-1:0]    tx_ch,
    input  logic [7:0]        tx_data,
    output logic [NUM_CH-1:0] tx_full,
    input  logic              rx_rd,
    input  logic [CHW-1:0]    rx_ch,
    output logic [7:0]        rx_data,
    output logic [NUM_CH-1:0] rx_empty,
    output logic              busy,
    output logic [CHW-1:0]    act_ch,
    output logic              done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    state_t         state, state_nxt;
    logic [3:0]     bit_cnt, bit_cnt_nxt;
    logic [7:0]     shreg, shreg_nxt;
    logic           rw, rw_nxt;
    logic           ack, ack_nxt;
    logic           stretch, stretch_nxt;
    logic           addressed, addressed_nxt;
    logic [CHW-1:0] act_ch_nxt;
    logic           load, tx_pop, rx_push;

    logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [NUM_CH-1:0] tx_empty_v, rx_full_v;
    logic [7:0]        tx_head_v [NUM_CH];
    logic [7:0]        rx_head_v [NUM_CH];
    logic [7:0]        addr_diff;
    logic              addr_match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {scl_s1, scl_s2, scl_d} <= 3'b111;
            {sda_s1, sda_s2, sda_d} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_d} <= {scl_i, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_d} <= {sda_i, sda_s1, sda_s2};
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

    // Unsigned wrap makes addresses below BASE_ADDR land far above NUM_CH.
    assign addr_diff  = {1'b0, shreg[7:1]} - {1'b0, BASE_ADDR};
    assign addr_match = addr_diff < 8'(NUM_CH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            rw        <= 1'b0;
            ack       <= 1'b0;
            stretch   <= 1'b0;
            addressed <= 1'b0;
            act_ch    <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            rw        <= rw_nxt;
            ack       <= ack_nxt;
            stretch   <= stretch_nxt;
            addressed <= addressed_nxt;
            act_ch    <= act_ch_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        rw_nxt        = rw;
        ack_nxt       = ack;
        stretch_nxt   = stretch;
        addressed_nxt = addressed;
        act_ch_nxt    = act_ch;
        load          = 1'b0;
        tx_pop        = 1'b0;
        rx_push       = 1'b0;
        if (stop_det) begin
            state_nxt     = IDLE;
            stretch_nxt   = 1'b0;
            addressed_nxt = 1'b0;
        end else if (start_det) begin
            state_nxt     = ADDR;
            bit_cnt_nxt   = '0;
            stretch_nxt   = 1'b0;
            addressed_nxt = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shreg_nxt   = {shreg[6:0], sda_s2};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (addr_match) begin
                            state_nxt     = ADDR_ACK;
                            act_ch_nxt    = addr_diff[CHW-1:0];
                            addressed_nxt = 1'b1;
                            rw_nxt        = shreg[0];
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            load = 1'b1;
                        end else begin
                            state_nxt   = WR_BYTE;
                            bit_cnt_nxt = '0;
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shreg_nxt   = {shreg[6:0], sda_s2};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            ack_nxt = ~rx_full_v[act_ch];
                            rx_push = ~rx_full_v[act_ch];
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_nxt = ack ? WR_ACK : IGNORE;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state_nxt   = WR_BYTE;
                        bit_cnt_nxt = '0;
                    end
                end
                RD_BYTE: begin
                    if (stretch) begin
                        if (!tx_empty_v[act_ch]) begin
                            tx_pop      = 1'b1;
                            shreg_nxt   = tx_head_v[act_ch];
                            stretch_nxt = 1'b0;
                        end
                    end else if (scl_rise && bit_cnt != 4'd8) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) state_nxt = RD_ACK;
                        else                 shreg_nxt = {shreg[6:0], 1'b1};
                    end
                end
                RD_ACK: begin
                    if (scl_rise) ack_nxt = ~sda_s2;
                    else if (scl_fall) begin
                        if (ack) load = 1'b1;
                        else     state_nxt = IGNORE;
                    end
                end
                default: ;
            endcase
        end
        // Shared pop point for the address-ACK and data-ACK exits of a read.
        if (load) begin
            state_nxt   = RD_BYTE;
            bit_cnt_nxt = '0;
            if (!tx_empty_v[act_ch]) begin
                tx_pop    = 1'b1;
                shreg_nxt = tx_head_v[act_ch];
            end else begin
`ifdef I2C_TGT_CLK_STRETCH_EN
                stretch_nxt = 1'b1;
`else
                shreg_nxt = 8'hFF;
`endif
            end
        end
    end

    always_comb begin
        sda_oe = 1'b0;
        case (state)
            ADDR_ACK, WR_ACK: sda_oe = 1'b1;
            RD_BYTE:          sda_oe = ~stretch & ~shreg[7];
            default:          sda_oe = 1'b0;
        endcase
        busy = addressed && (state != IDLE) && (state != IGNORE);
        done = stop_det & addressed;
`ifdef I2C_TGT_CLK_STRETCH_EN
        scl_oe = stretch;
`else
        scl_oe = 1'b0;
`endif
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [7:0] tx_mem [FIFO_DEPTH];
        logic [7:0] rx_mem [FIFO_DEPTH];
        logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
        logic tx_we, tx_re, rx_we, rx_re;

        assign tx_full[k]    = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
        assign tx_empty_v[k] = (tx_wp == tx_rp);
        assign rx_full_v[k]  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
        assign rx_empty[k]   = (rx_wp == rx_rp);

        assign tx_we = tx_wr && (tx_ch == CHW'(k)) && !tx_full[k];
        assign tx_re = tx_pop && (act_ch == CHW'(k)) && !tx_empty_v[k];
        assign rx_we = rx_push && (act_ch == CHW'(k)) && !rx_full_v[k];
        assign rx_re = rx_rd && (rx_ch == CHW'(k)) && !rx_empty[k];

        assign tx_head_v[k] = tx_mem[tx_rp[AW-1:0]];
        assign rx_head_v[k] = rx_mem[rx_rp[AW-1:0]];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                tx_wp <= '0;
                tx_rp <= '0;
                rx_wp <= '0;
                rx_rp <= '0;
            end else begin
                if (tx_we) tx_wp <= tx_wp + (AW+1)'(1);
                if (tx_re) tx_rp <= tx_rp + (AW+1)'(1);
                if (rx_we) rx_wp <= rx_wp + (AW+1)'(1);
                if (rx_re) rx_rp <= rx_rp + (AW+1)'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (tx_we) tx_mem[tx_wp[AW-1:0]] <= tx_data;
            if (rx_we) rx_mem[rx_wp[AW-1:0]] <= {shreg[6:0], sda_s2};
        end
    end

    assign rx_data = rx_head_v[rx_ch];

endmodule
